// File: rtl/riscv_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the RISC-V memory-side responders.
//   - mem_state_e     : responder FSM states (IDLE / WAIT / RESP)
//   - DWORD_BYTES,
//     ADDR_W, DATA_W  : doubleword geometry and bus widths
//   - ERR_*_BIT       : positions of the error flags inside an error vector,
//                       shared with the future instruction-memory responder
// -----------------------------------------------------------------------------
package riscv_mem_pkg;

    localparam int unsigned DWORD_BYTES = 8;
    localparam int unsigned ADDR_W      = 64;
    localparam int unsigned DATA_W      = 64;

    localparam int unsigned ERR_W              = 2;
    localparam int unsigned ERR_MISALIGNED_BIT = 0;
    localparam int unsigned ERR_INVALID_BIT    = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } mem_state_e;

endpackage : riscv_mem_pkg

// File: rtl/riscv_datamem_array.sv
// -----------------------------------------------------------------------------
// riscv_datamem_array
// DEPTH_WORDS x 64-bit storage for the data-memory responder.
// Synchronous byte-enabled write, combinational read by the same index.
// Ports:
//   clk      in   clock, rising edge
//   we_i     in   write enable
//   idx_i    in   doubleword index (read and write)
//   wdata_i  in   write data
//   wstrb_i  in   per-byte write enables (bit i -> bits 8*i+7:8*i)
//   rdata_o  out  read data at idx_i
// -----------------------------------------------------------------------------
module riscv_datamem_array
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [IDX_W-1:0]       idx_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic [DWORD_BYTES-1:0] wstrb_i,
    output logic [DATA_W-1:0]      rdata_o
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    // NOTE: the storage has no reset branch on purpose: its contents must
    // survive rstn, and leaving it out lets the tools map it onto RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < int'(DWORD_BYTES); b++) begin
                if (wstrb_i[b]) begin
                    r_mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = r_mem[idx_i];

endmodule : riscv_datamem_array

// File: rtl/riscv_datamem_resp.sv
// -----------------------------------------------------------------------------
// riscv_datamem_resp
// Memory-side responder for the core's data load/store port. Accepts one
// request at a time over valid/ready, waits WAIT_CYCLES extra cycles, then
// presents load data plus misaligned/invalid flags until the requester
// takes the response.
// Optional build macro: RISCV_DATAMEM_STRB_EN adds req_strb_i byte strobes
// for stores; without it every store writes all 8 bytes.
// Ports:
//   clk, rstn               clock / asynchronous active-low reset
//   req_valid_i/ready_o     request handshake (ready only in IDLE)
//   req_we_i                1 = store, 0 = load
//   req_addr_i, req_wdata_i byte address and store data
//   req_strb_i              byte strobes (RISCV_DATAMEM_STRB_EN only)
//   resp_valid_o/ready_i    response handshake
//   resp_rdata_o            load data, 0 for stores and errored requests
//   resp_err_misaligned_o   address not doubleword aligned
//   resp_err_invalid_o      address outside the mapped window
//   busy_o                  FSM not idle
// -----------------------------------------------------------------------------
module riscv_datamem_resp
    import riscv_mem_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 64'h0,
    parameter int unsigned       WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
`ifdef RISCV_DATAMEM_STRB_EN
    input  logic [DWORD_BYTES-1:0] req_strb_i,
`endif
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_misaligned_o,
    output logic              resp_err_invalid_o,
    output logic              busy_o
);

    localparam int unsigned       IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] SIZE_B    = ADDR_W'(DEPTH_WORDS) * ADDR_W'(DWORD_BYTES);
    localparam logic [3:0]        CNT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit                ZERO_WAIT = (WAIT_CYCLES == 0);

    mem_state_e r_state;
    mem_state_e w_next_state;
    logic [3:0] r_cnt;

    // Latched request
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    // Response registers
    logic [DATA_W-1:0] r_rdata;
    logic [ERR_W-1:0]  r_err;

    logic                   w_accept;
    logic                   w_enter_resp;
    logic                   w_resp_done;
    logic                   w_txn_we;
    logic [ADDR_W-1:0]      w_txn_addr;
    logic [DATA_W-1:0]      w_txn_wdata;
    logic [DWORD_BYTES-1:0] w_txn_strb;
    logic [ADDR_W-1:0]      w_offset;
    logic [ERR_W-1:0]       w_err_vec;
    logic [IDX_W-1:0]       w_index;
    logic                   w_arr_we;
    logic [DATA_W-1:0]      w_arr_rdata;

    assign req_ready_o  = (r_state == S_IDLE);
    assign resp_valid_o = (r_state == S_RESP);
    assign busy_o       = (r_state != S_IDLE);
    assign w_accept     = req_valid_i & req_ready_o;
    assign w_resp_done  = resp_valid_o & resp_ready_i;

    // With zero wait states RESP is entered on the acceptance edge itself,
    // before the latch holds anything, so the commit path looks at the live
    // inputs while idle and at the latched copy otherwise.
    assign w_txn_we    = (r_state == S_IDLE) ? req_we_i    : r_we;
    assign w_txn_addr  = (r_state == S_IDLE) ? req_addr_i  : r_addr;
    assign w_txn_wdata = (r_state == S_IDLE) ? req_wdata_i : r_wdata;

`ifdef RISCV_DATAMEM_STRB_EN
    logic [DWORD_BYTES-1:0] r_strb;
    assign w_txn_strb = (r_state == S_IDLE) ? req_strb_i : r_strb;
`else
    assign w_txn_strb = '1;
`endif

    // An address below BASE_ADDR wraps to an offset of at least SIZE_B
    // (no overflow of BASE_ADDR+size is guaranteed), so one unsigned compare
    // covers both ends of the window.
    assign w_offset = w_txn_addr - BASE_ADDR;
    assign w_index  = IDX_W'(w_offset >> 3);

    // NOTE: every signal written in an always_comb gets a default first so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        w_err_vec                     = '0;
        w_err_vec[ERR_MISALIGNED_BIT] = |w_txn_addr[2:0];
        w_err_vec[ERR_INVALID_BIT]    = (w_offset >= SIZE_B);
    end

    assign w_arr_we = w_enter_resp & w_txn_we & ~(|w_err_vec);

    riscv_datamem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (w_arr_we),
        .idx_i   (w_index),
        .wdata_i (w_txn_wdata),
        .wstrb_i (w_txn_strb),
        .rdata_o (w_arr_rdata)
    );

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        w_enter_resp = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = ZERO_WAIT ? S_RESP : S_WAIT;
                    w_enter_resp = ZERO_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready_i) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Wait-state counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request latch
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
`ifdef RISCV_DATAMEM_STRB_EN
            r_strb  <= '0;
`endif
        end else if (w_accept) begin
            r_we    <= req_we_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
`ifdef RISCV_DATAMEM_STRB_EN
            r_strb  <= req_strb_i;
`endif
        end
    end

    // Response data and flags: loaded on RESP entry, held through
    // backpressure, cleared on the completing handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdata <= '0;
            r_err   <= '0;
        end else if (w_enter_resp) begin
            r_rdata <= (w_txn_we || (|w_err_vec)) ? '0 : w_arr_rdata;
            r_err   <= w_err_vec;
        end else if (w_resp_done) begin
            r_rdata <= '0;
            r_err   <= '0;
        end
    end

    assign resp_rdata_o          = r_rdata;
    assign resp_err_misaligned_o = r_err[ERR_MISALIGNED_BIT];
    assign resp_err_invalid_o    = r_err[ERR_INVALID_BIT];

endmodule : riscv_datamem_resp

// File: tb/tb_riscv_datamem_resp.sv
// -----------------------------------------------------------------------------
// tb_riscv_datamem_resp
// Directed bench for riscv_datamem_resp. Three instances:
//   0: WAIT_CYCLES=2, BASE_ADDR=0
//   1: WAIT_CYCLES=2, BASE_ADDR=0x1000
//   2: WAIT_CYCLES=0, BASE_ADDR=0
// Build with RISCV_DATAMEM_STRB_EN defined to also cover byte strobes.
// -----------------------------------------------------------------------------
module tb_riscv_datamem_resp;

    localparam int NDUT = 3;
    localparam logic [63:0] PAT_A = 64'hDEAD_BEEF_CAFE_F00D;

    logic        clk;
    logic        rstn;
    logic        req_valid  [NDUT];
    logic        req_we     [NDUT];
    logic [63:0] req_addr   [NDUT];
    logic [63:0] req_wdata  [NDUT];
    logic [7:0]  req_strb   [NDUT];
    logic        resp_ready [NDUT];
    logic        req_ready  [NDUT];
    logic        resp_valid [NDUT];
    logic [63:0] rdata      [NDUT];
    logic        err_mis    [NDUT];
    logic        err_inv    [NDUT];
    logic        busy       [NDUT];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        riscv_datamem_resp #(
            .DEPTH_WORDS (256),
            .BASE_ADDR   ((g == 1) ? 64'h1000 : 64'h0),
            .WAIT_CYCLES ((g == 2) ? 0 : 2)
        ) u_dut (
            .clk                   (clk),
            .rstn                  (rstn),
            .req_valid_i           (req_valid[g]),
            .req_ready_o           (req_ready[g]),
            .req_we_i              (req_we[g]),
            .req_addr_i            (req_addr[g]),
            .req_wdata_i           (req_wdata[g]),
`ifdef RISCV_DATAMEM_STRB_EN
            .req_strb_i            (req_strb[g]),
`endif
            .resp_valid_o          (resp_valid[g]),
            .resp_ready_i          (resp_ready[g]),
            .resp_rdata_o          (rdata[g]),
            .resp_err_misaligned_o (err_mis[g]),
            .resp_err_invalid_o    (err_inv[g]),
            .busy_o                (busy[g])
        );
    end

    // One request on instance d; returns once resp_valid is seen at a
    // falling edge. lat counts rising edges from the acceptance edge on.
    task automatic txn(input int d, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] strb,
                       output int lat, output logic [63:0] rd,
                       output logic mis, output logic inv);
        bit seen = 1'b0;
        @(negedge clk);
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_strb[d]  = strb;
        req_valid[d] = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 req_valid[d] = 1'b0;
            lat++;
            @(negedge clk);
            if (resp_valid[d] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout dut=%0d addr=%h: no resp_valid within 40 cycles", d, addr);
        end
        rd  = rdata[d];
        mis = err_mis[d];
        inv = err_inv[d];
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if ({req_ready[d], resp_valid[d], busy[d], err_mis[d], err_inv[d]} !== 5'b10000
                || rdata[d] !== 64'h0) begin
                errors++;
                $display("FAIL reset_state dut=%0d got rdy/vld/busy/mis/inv=%b%b%b%b%b rdata=%h exp 10000 rdata=0",
                         d, req_ready[d], resp_valid[d], busy[d], err_mis[d], err_inv[d], rdata[d]);
            end
        end
        rstn = 1'b1;
    endtask

    task automatic test_store_load();
        int lat; logic [63:0] rd; logic m, v;
        txn(0, 1'b1, 64'h10, PAT_A, 8'hFF, lat, rd, m, v);
        checks++;
        if (lat !== 3 || rd !== 64'h0 || m !== 1'b0 || v !== 1'b0) begin
            errors++;
            $display("FAIL store_0x10 got lat=%0d rd=%h mis=%b inv=%b exp lat=3 rd=0 mis=0 inv=0", lat, rd, m, v);
        end
        txn(0, 1'b0, 64'h10, 64'h0, 8'hFF, lat, rd, m, v);
        checks++;
        if (lat !== 3 || rd !== PAT_A || m !== 1'b0 || v !== 1'b0) begin
            errors++;
            $display("FAIL load_0x10 got lat=%0d rd=%h mis=%b inv=%b exp lat=3 rd=%h no errors", lat, rd, m, v, PAT_A);
        end
    endtask

    task automatic test_misaligned();
        int lat; logic [63:0] rd; logic m, v;
        txn(0, 1'b0, 64'h13, 64'h0, 8'hFF, lat, rd, m, v);
        checks++;
        if (rd !== 64'h0 || m !== 1'b1 || v !== 1'b0) begin
            errors++;
            $display("FAIL load_0x13 got rd=%h mis=%b inv=%b exp rd=0 mis=1 inv=0", rd, m, v);
        end
        txn(0, 1'b1, 64'h13, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, lat, rd, m, v);
        checks++;
        if (m !== 1'b1 || v !== 1'b0) begin
            errors++;
            $display("FAIL store_0x13 got mis=%b inv=%b exp mis=1 inv=0", m, v);
        end
        txn(0, 1'b0, 64'h10, 64'h0, 8'hFF, lat, rd, m, v);
        checks++;
        if (rd !== PAT_A || m !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_no_write got rd=%h mis=%b exp rd=%h mis=0", rd, m, PAT_A);
        end
    endtask

    task automatic test_invalid();
        int lat; logic [63:0] rd; logic m, v;
        // {dut, addr, exp mis, exp inv}
        int          vd  [7] = '{0, 0, 0, 1, 1, 1, 1};
        logic [63:0] va  [7] = '{64'h800, 64'h803, 64'h7F8, 64'hFF8, 64'h1000, 64'h17F8, 64'h1800};
        logic        vm  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        vi  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            txn(vd[k], 1'b0, va[k], 64'h0, 8'hFF, lat, rd, m, v);
            checks++;
            if (m !== vm[k] || v !== vi[k] || (vi[k] && rd !== 64'h0)) begin
                errors++;
                $display("FAIL range dut=%0d addr=%h got mis=%b inv=%b rd=%h exp mis=%b inv=%b",
                         vd[k], va[k], m, v, rd, vm[k], vi[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [63:0] rd; logic m, v;
        resp_ready[0] = 1'b0;
        txn(0, 1'b0, 64'h10, 64'h0, 8'hFF, lat, rd, m, v);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (resp_valid[0] !== 1'b1 || rdata[0] !== PAT_A || err_mis[0] !== 1'b0
                || err_inv[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d got vld=%b rd=%h mis=%b inv=%b rdy=%b exp 1 %h 0 0 0",
                         c, resp_valid[0], rdata[0], err_mis[0], err_inv[0], req_ready[0], PAT_A);
            end
        end
        resp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || busy[0] !== 1'b0 || rdata[0] !== 64'h0) begin
            errors++;
            $display("FAIL backpressure_release got vld=%b rdy=%b busy=%b rd=%h exp 0 1 0 0",
                     resp_valid[0], req_ready[0], busy[0], rdata[0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] rd; logic m, v;
        txn(0, 1'b1, 64'h20, 64'h1111, 8'hFF, lat, rd, m, v);
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 64'h20; req_wdata[0] = 64'h2222; req_strb[0] = 8'hFF;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1 || req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL wait_state got busy=%b rdy=%b exp busy=1 rdy=0", busy[0], req_ready[0]);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (busy[0] !== 1'b0 || req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || rdata[0] !== 64'h0) begin
            errors++;
            $display("FAIL async_reset got busy=%b rdy=%b vld=%b rd=%h exp 0 1 0 0",
                     busy[0], req_ready[0], resp_valid[0], rdata[0]);
        end
        @(negedge clk);
        rstn = 1'b1;
        txn(0, 1'b0, 64'h20, 64'h0, 8'hFF, lat, rd, m, v);
        checks++;
        if (rd !== 64'h1111 || lat !== 3) begin
            errors++;
            $display("FAIL reset_discards_store got rd=%h lat=%0d exp rd=1111 lat=3", rd, lat);
        end
    endtask

    task automatic test_zero_wait();
        int lat; logic [63:0] rd; logic m, v;
        txn(2, 1'b1, 64'h8, 64'h0123_4567_89AB_CDEF, 8'hFF, lat, rd, m, v);
        checks++;
        if (lat !== 1 || rd !== 64'h0) begin
            errors++;
            $display("FAIL zero_wait_store got lat=%0d rd=%h exp lat=1 rd=0", lat, rd);
        end
        txn(2, 1'b0, 64'h8, 64'h0, 8'hFF, lat, rd, m, v);
        checks++;
        if (lat !== 1 || rd !== 64'h0123_4567_89AB_CDEF || m !== 1'b0 || v !== 1'b0) begin
            errors++;
            $display("FAIL zero_wait_load got lat=%0d rd=%h exp lat=1 rd=0123456789abcdef", lat, rd);
        end
    endtask

`ifdef RISCV_DATAMEM_STRB_EN
    task automatic test_strobe();
        int lat; logic [63:0] rd; logic m, v;
        txn(0, 1'b1, 64'h20, 64'h1111_1111_1111_1111, 8'hFF, lat, rd, m, v);
        txn(0, 1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, lat, rd, m, v);
        txn(0, 1'b0, 64'h20, 64'h0, 8'h00, lat, rd, m, v);
        checks++;
        if (rd !== 64'h1111_1111_FFFF_FFFF) begin
            errors++;
            $display("FAIL strobe_low_half got rd=%h exp 11111111ffffffff", rd);
        end
        txn(0, 1'b1, 64'h20, 64'h0, 8'h00, lat, rd, m, v);
        txn(0, 1'b0, 64'h20, 64'h0, 8'h00, lat, rd, m, v);
        checks++;
        if (rd !== 64'h1111_1111_FFFF_FFFF || m !== 1'b0 || v !== 1'b0) begin
            errors++;
            $display("FAIL strobe_zero got rd=%h exp 11111111ffffffff", rd);
        end
    endtask
`endif

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_addr[d]   = 64'h0;
            req_wdata[d]  = 64'h0;
            req_strb[d]   = 8'hFF;
            resp_ready[d] = 1'b1;
        end
        test_reset();
        test_store_load();
        test_misaligned();
        test_invalid();
        test_backpressure();
        test_reset_mid();
        test_zero_wait();
`ifdef RISCV_DATAMEM_STRB_EN
        test_strobe();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_riscv_datamem_resp

// File: doc/riscv_datamem_resp.md
Name: riscv_datamem_resp

Overview:
Responder (memory side) for the core's data-memory load/store port, using a valid/ready request/response handshake with configurable wait states.
- Replaces the zero-latency combinational data memory, so the core and future cache/bus work can be exercised against realistic multi-cycle latency.
- Checks doubleword alignment and address range, owns the storage array, and returns read data plus error flags with each response.

Parameters:
DEPTH_WORDS, 256, number of 64-bit doublewords stored
BASE_ADDR, 64'h0, byte address of doubleword 0
WAIT_CYCLES, 2, extra cycles between request acceptance and response valid (0..15)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
req_valid_i  in  1  request present
req_ready_o  out  1  responder can accept request
req_we_i  in  1  1 = store (SD), 0 = load (LD)
req_addr_i  in  64  byte address
req_wdata_i  in  64  store data
resp_valid_o  out  1  response present
resp_ready_i  in  1  requester accepts response
resp_rdata_o  out  64  load data; 0 for stores and errored requests
resp_err_misaligned_o  out  1  addr[2:0] != 0
resp_err_invalid_o  out  1  address outside [BASE_ADDR, BASE_ADDR+8*DEPTH_WORDS)
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset values (asynchronous, rstn=0): state IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, both error flags 0, busy_o=0, wait counter 0.
- Storage array is not reset; its contents survive rstn.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o: latch we/addr/wdata and compute both error flags from the latched address.
  - If WAIT_CYCLES==0 go to RESP; else load counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - req_ready_o=0.
  - Counter decrements each cycle; at 0, go to RESP on the next edge.
  - Total latency from acceptance edge to resp_valid_o high is WAIT_CYCLES+1 cycles.
- Entry into RESP (same edge):
  - Store with no error: array[index] <= wdata.
  - Load with no error: resp_rdata_o <= array[index].
  - Error (either flag): no write; resp_rdata_o <= 0.
  - index = (addr - BASE_ADDR) >> 3.
  - Misaligned and invalid may both be set together.
- RESP:
  - resp_valid_o=1; rdata and flags are held stable until resp_ready_i=1.
  - On handshake, go to IDLE and drop resp_valid_o/flags/rdata to 0 on the next edge.
- Throughput: one request per WAIT_CYCLES+2 cycles at best. No request is accepted in the cycle a response completes; req_ready_o is high only in IDLE.
- Read-after-write to the same address returns the new data, since the store commits before any later request is accepted.
- Range check uses 64-bit unsigned compare. An address at or above BASE_ADDR+8*DEPTH_WORDS is invalid; wrap-around of BASE_ADDR+size is not supported (the integrator guarantees no overflow).
- Reset mid-operation:
  - A request in WAIT is discarded with no write.
  - A store already committed on entry to RESP stays committed.
- req_* inputs are ignored outside IDLE; the requester must hold them stable only until the handshake.

Optional Feature:
Macro RISCV_DATAMEM_STRB_EN.
- Defined: adds port req_strb_i (in, 8), latched with the request. Only bytes with strb[i]=1 are written. A store with strb=0 completes normally with no change. Loads ignore strb.
- Undefined: port absent; stores always write all 8 bytes.

Decomposition:
- Package riscv_mem_pkg:
  - FSM state enum (IDLE/WAIT/RESP)
  - DWORD_BYTES=8, ADDR_W=64, DATA_W=64
  - Error-flag bit positions, for reuse by the future instruction-memory responder
- One sub-module: riscv_datamem_array.
  - DEPTH_WORDS x 64 storage.
  - Synchronous write with per-byte enables (tied all-ones when the macro is off).
  - Combinational read by index.
  - No reset.

Test Plan:
- WAIT_CYCLES=2, BASE=0, resp_ready_i=1: store 0xDEADBEEF_CAFEF00D to 0x10, then load 0x10. Each resp_valid_o rises exactly 3 cycles after acceptance. Load rdata=0xDEADBEEF_CAFEF00D with no error flags.
- Load 0x13 -> resp_err_misaligned_o=1, rdata=0. Then store to 0x13 followed by load 0x10 -> old value unchanged.
- Load 8*DEPTH_WORDS (0x800) -> resp_err_invalid_o=1. Load 0x7F8 -> no error. With BASE=0x1000, load 0x0FF8 -> invalid.
- Backpressure: hold resp_ready_i=0 for 5 cycles. resp_valid_o, rdata and flags stay stable and req_ready_o stays 0; on release, IDLE follows the next cycle.
- Assert rstn=0 during WAIT of a store to 0x20 (previously 0x1111). All outputs reset immediately; a later load of 0x20 returns 0x1111. WAIT_CYCLES=0 variant: response valid 1 cycle after acceptance.
- RISCV_DATAMEM_STRB_EN defined: 0x20 holds 0x1111...1111; store 0xFFFF...FFFF with strb=8'h0F, then load 0x20 -> 0x11111111_FFFFFFFF.
